uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART `transmitter` between `NUM_REQ` byte producers. It sits directly in front of the transmitter and performs four jobs:
- accepts one byte from the selected requester;
- issues a single-cycle `tx_start`;
- holds `tx_data` stable for the whole frame, because the transmitter samples `d_in` during START and again during PARITY;
- waits for `tx_done` before granting the next requester.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `BITS_PER_DATA`, 8, byte width; must match the transmitter
- `TIMEOUT_CYCLES`, 65536, clock cycles allowed in WAIT before abort (only used with `UART_TX_SCHED_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock for the whole block
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a byte pending
- `req_data`  in  NUM_REQ*BITS_PER_DATA  byte of requester i at bits [i*BITS_PER_DATA +: BITS_PER_DATA]
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: requester i's byte was captured
- `tx_start`  out  1  to transmitter `tx_start`
- `tx_data`  out  BITS_PER_DATA  to transmitter `d_in`
- `tx_done`  in  1  from transmitter `tx_done`
- `grant_id`  out  clog2(NUM_REQ)  index of the requester owning the current or last frame
- `busy`  out  1  high in LAUNCH and WAIT
- `timeout_err`  out  1  one-cycle pulse when a frame is aborted by timeout

## Operation
States:
- IDLE. If any `req_valid` is set, select the first set bit at or after `rr_ptr`, searching upward with wrap.
  - At the clock edge: capture that requester's byte into `tx_data`, set `grant_id`, set `rr_ptr` to (grant+1) mod NUM_REQ, go to LAUNCH.
  - If no `req_valid` is set, stay in IDLE.
- LAUNCH. Exactly one cycle, then go to WAIT unconditionally.
  - `tx_start`=1.
  - `req_ready[grant_id]`=1. The requester may drop or change `req_valid`/`req_data` from the next cycle on.
- WAIT. `tx_data` is held. When `tx_done`=1, go to IDLE.

Rules:
- `req_valid` is ignored outside IDLE.
- `tx_done` is ignored in IDLE and LAUNCH.
- A requester holding `req_valid` continuously gets every NUM_REQ-th slot when all requesters are active. No requester starves.
- Requests arriving mid-frame wait in the requester; nothing is queued in this block.
- `tx_data` changes only on the IDLE→LAUNCH edge.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: all outputs 0; `rr_ptr`=0; state IDLE.
- Reset asserted mid-frame: the block returns to IDLE immediately and `tx_start` drops. The transmitter is reset by the same `reset` net.
- Request latency: `req_valid` high in IDLE → `tx_start` and `req_ready` high on the next cycle.
- `tx_done` observed in WAIT → back in IDLE on the next cycle. A pending request gets `tx_start` one cycle after that, so frames are separated by 2 clocks beyond the transmitter's own IDLE.
- `busy` equals (state != IDLE), registered.
- If `tx_done` and `reset` occur in the same cycle, reset wins.

## Configuration
Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits is cleared on entering WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without `tx_done`: the state returns to IDLE, `timeout_err` pulses for one cycle, and `rr_ptr` advances normally.
  - If `tx_done` arrives in the same cycle as the timeout, `tx_done` wins and there is no error.
- Not defined: no counter; WAIT lasts until `tx_done`; `timeout_err` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - state localparams for IDLE/LAUNCH/WAIT (one-hot, 3 bits);
  - the `clog2` function;
  - the default `BITS_PER_DATA`.
- Sub-module `rr_arbiter`: combinational. Takes `req_valid` and `rr_ptr`; produces a one-hot grant, an encoded index and `any_req`. The FSM, data mux/register and timeout counter live in `uart_tx_sched`.

## Test plan
- Single request: `req_valid`=4'b0100, `req_data[2]`=8'hA5 → `req_ready`=4'b0100 and `tx_start` in the same cycle; `tx_data`=8'hA5 held until `tx_done`; `grant_id`=2.
- All four requesters valid continuously, bytes 8'h10/8'h21/8'h32/8'h43, `tx_done` modelled 170 cycles after `tx_start` → grant order 0,1,2,3,0,1… and `tx_data` order 10,21,32,43.
- Wrap: `rr_ptr`=3, `req_valid`=4'b0011 → grant 0, then 1.
- `reset` pulsed 20 cycles into WAIT → all outputs 0 the same cycle; the next request is granted starting from requester 0.
- With `UART_TX_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=32, `tx_done` never asserted → `timeout_err` pulses once; back in IDLE; the next requester is served. Repeat with `tx_done` coinciding with the timeout → no `timeout_err`.
- Spurious `tx_done` pulse in IDLE and in LAUNCH → no state change; `tx_start` remains a single-cycle pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   ST_IDLE / ST_LAUNCH / ST_WAIT : one-hot scheduler state encodings (3 bits)
//   UART_BITS_PER_DATA            : default byte width of the transmitter
//   clog2()                       : ceiling log2 used for index and counter widths
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_LAUNCH = 3'b010;
  localparam logic [2:0] ST_WAIT   = 3'b100;

  localparam int unsigned UART_BITS_PER_DATA = 8;

  // Minimum of 1 so that a 1-entry space still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_valid  in   NUM_REQ        pending requests
//   rr_ptr     in   clog2(NUM_REQ) highest-priority requester this round
//   grant_oh   out  NUM_REQ        one-hot grant (all zero when nothing pending)
//   grant_idx  out  clog2(NUM_REQ) encoded grant (0 when nothing pending)
//   any_req    out  1              at least one request pending
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]        grant_oh,
  output logic [clog2(NUM_REQ)-1:0] grant_idx,
  output logic                      any_req
);

  localparam int unsigned GW = clog2(NUM_REQ);

  int unsigned idx;
  logic        found;

  // Walk upward from rr_ptr with wrap; first set bit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = |req_valid;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. Captures the granted byte, fires a one-cycle tx_start, holds
// tx_data for the whole frame and waits for tx_done before the next grant.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN (abort WAIT after
// TIMEOUT_CYCLES cycles without tx_done and pulse timeout_err).
// Ports:
//   clk          in   1                       clock
//   reset        in   1                       asynchronous active-high reset
//   req_valid    in   NUM_REQ                 requester i has a byte pending
//   req_data     in   NUM_REQ*BITS_PER_DATA   byte i at [i*BITS_PER_DATA +: BITS_PER_DATA]
//   req_ready    out  NUM_REQ                 one-hot pulse: byte i captured
//   tx_start     out  1                       single-cycle start to transmitter
//   tx_data      out  BITS_PER_DATA           byte to transmitter d_in, held per frame
//   tx_done      in   1                       frame complete from transmitter
//   grant_id     out  clog2(NUM_REQ)          owner of the current / last frame
//   busy         out  1                       high in LAUNCH and WAIT
//   timeout_err  out  1                       pulse when a frame is aborted by timeout
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BITS_PER_DATA  = UART_BITS_PER_DATA,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*BITS_PER_DATA-1:0]  req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              tx_start,
  output logic [BITS_PER_DATA-1:0]          tx_data,
  input  logic                              tx_done,
  output logic [clog2(NUM_REQ)-1:0]         grant_id,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int unsigned GW = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_sched: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_sched: TIMEOUT_CYCLES must be at least 2");
  end

  logic [2:0]               state;
  logic [GW-1:0]            rr_ptr;
  logic [NUM_REQ-1:0]       grant_oh_q;

  logic [NUM_REQ-1:0]       arb_oh;
  logic [GW-1:0]            arb_idx;
  logic                     arb_any;
  logic [BITS_PER_DATA-1:0] arb_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    arb_data = req_data[arb_idx*BITS_PER_DATA +: BITS_PER_DATA];
  end

  // Outputs decode straight from flops so an async reset clears them at once.
  assign tx_start  = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_LAUNCH) ? grant_oh_q : '0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_err_q;

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_oh_q <= '0;
      grant_id   <= '0;
      tx_data    <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt     <= '0;
      to_err_q   <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            tx_data    <= arb_data;
            grant_id   <= arb_idx;
            grant_oh_q <= arb_oh;
            rr_ptr     <= GW'((32'(arb_idx) + 1) % NUM_REQ);
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          // tx_done takes precedence over a timeout landing in the same cycle.
          if (tx_done) begin
            state <= ST_IDLE;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state    <= ST_IDLE;
            to_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BPD     = 8;
  localparam int unsigned TO_CYC  = 32;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*BPD-1:0]   req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     tx_start;
  logic [BPD-1:0]           tx_data;
  logic                     tx_done;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     timeout_err;

  int unsigned n_checks;
  int unsigned n_errors;

  uart_tx_sched #(
    .NUM_REQ        (NUM_REQ),
    .BITS_PER_DATA  (BPD),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic set_byte(input int unsigned i, input logic [7:0] v);
    req_data[i*BPD +: BPD] = v;
  endtask

  task automatic check_launch(input string tag, input logic [1:0] g, input logic [7:0] d);
    check({tag, "_start"}, 32'(tx_start), 32'd1);
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
    check({tag, "_grant"}, 32'(grant_id), 32'(g));
    check({tag, "_data"},  32'(tx_data), 32'(d));
    check({tag, "_busy"},  32'(busy), 32'd1);
  endtask

  // From a WAIT cycle: pulse tx_done, land in IDLE.
  task automatic finish_frame(input string tag);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    ticks(2);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_data",  32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_toerr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();

    // Single request from requester 2
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'hA5); set_byte(3, 8'h44);
    req_valid = 4'b0100;
    tick();
    check_launch("single", 2'd2, 8'hA5);
    req_valid = '0;
    set_byte(2, 8'hFF);
    tick();
    check("single_start_pulse", 32'(tx_start), 32'd0);
    check("single_ready_pulse", 32'(req_ready), 32'd0);
    ticks(5);
    check("single_hold", 32'(tx_data), 32'hA5);
    check("single_wait_busy", 32'(busy), 32'd1);
    finish_frame("single");
    check("single_hold_idle", 32'(tx_data), 32'hA5);

    // Wrap: rr_ptr is 3, requesters 0 and 1 pending
    req_valid = 4'b0011;
    tick();
    check_launch("wrap0", 2'd0, 8'h11);
    tick();
    finish_frame("wrap0");
    tick();
    check_launch("wrap1", 2'd1, 8'h22);
    req_valid = '0;
    tick();
    finish_frame("wrap1");

    // Spurious tx_done in IDLE
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("spur_idle_busy",  32'(busy), 32'd0);
    check("spur_idle_start", 32'(tx_start), 32'd0);

    // Spurious tx_done in LAUNCH (rr_ptr is 2, only requester 0 pending)
    req_valid = 4'b0001;
    tick();
    check_launch("spur_l", 2'd0, 8'h11);
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    check("spur_l_start", 32'(tx_start), 32'd0);
    check("spur_l_busy1", 32'(busy), 32'd1);
    tick();
    check("spur_l_busy2", 32'(busy), 32'd1);
    finish_frame("spur_l");

    // Reset 20 cycles into WAIT (rr_ptr is 1; requester 2 -> rr_ptr 3)
    req_valid = 4'b0100;
    tick();
    check_launch("rstmid", 2'd2, 8'hFF);
    req_valid = '0;
    ticks(21);
    check("rstmid_wait", 32'(busy), 32'd1);
    reset   = 1'b1;
    tx_done = 1'b1;
    #1;
    check("rstmid_busy",  32'(busy), 32'd0);
    check("rstmid_data",  32'(tx_data), 32'd0);
    check("rstmid_grant", 32'(grant_id), 32'd0);
    check("rstmid_start", 32'(tx_start), 32'd0);
    tick();
    reset   = 1'b0;
    tx_done = 1'b0;

    // All four valid continuously: order from requester 0 after reset
    set_byte(0, 8'h10); set_byte(1, 8'h21); set_byte(2, 8'h32); set_byte(3, 8'h43);
    req_valid = 4'b1111;
    for (int unsigned f = 0; f < 6; f++) begin
      logic [1:0] g;
      logic [7:0] d;
      g = 2'(f % 4);
      d = 8'h10 + 8'(g) * 8'h11;
      tick();
      check_launch("rr", g, d);
      ticks(169);
      check("rr_hold", 32'(tx_data), 32'(d));
      check("rr_start_low", 32'(tx_start), 32'd0);
      finish_frame("rr");
    end
    req_valid = '0;
    tick();
    check("rr_drain", 32'(busy), 32'd0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // rr_ptr is 2; requester 0 served, requester 1 waits during the frame
    req_valid = 4'b0001;
    tick();
    check_launch("to", 2'd0, 8'h10);
    req_valid = 4'b0010;
    tick();
    ticks(31);
    check("to_pre_err",  32'(timeout_err), 32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    tick();
    check("to_err",  32'(timeout_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 32'd0);
    check_launch("to_next", 2'd1, 8'h21);
    req_valid = '0;
    tick();
    ticks(31);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("to_tie_err",  32'(timeout_err), 32'd0);
    check("to_tie_idle", 32'(busy), 32'd0);
`else
    // Without the timeout feature WAIT lasts until tx_done
    req_valid = 4'b0001;
    tick();
    check_launch("nto", 2'd0, 8'h10);
    req_valid = 4'b0010;
    ticks(41);
    check("nto_busy", 32'(busy), 32'd1);
    check("nto_err",  32'(timeout_err), 32'd0);
    finish_frame("nto");
    tick();
    check_launch("nto_next", 2'd1, 8'h21);
    req_valid = '0;
    tick();
    finish_frame("nto_next");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
